// File: rtl/mvm_sched_ctrl_if.sv
// -----------------------------------------------------------------------------
// mvm_sched_ctrl_if
// Bundles the handshake and control signals of the matrix-vector MAC
// sequencing controller. clk and reset stay plain ports of the controller.
//
// Signals:
//   input_valid / input_ready          x-element input stream
//   wr_en_x, wr_addr_x, wr_bank_x      x memory write port control
//   addr_x, rd_bank_x                  x memory read control
//   addr_w                             W read address shared by all lanes
//   clear_acc, en_acc, capture         lane accumulator strobes
//   out_sel, output_valid,
//   output_ready, output_last          result output stream (one lane per beat)
//
// Modports:
//   master : the controller (drives every control output)
//   slave  : the surrounding datapath / streaming environment
// -----------------------------------------------------------------------------
interface mvm_sched_ctrl_if #(
    parameter int N = 8,
    parameter int M = 16,
    parameter int P = 4
);
    localparam int XW = $clog2(N);
    localparam int AW = (M * N / P > 1) ? $clog2(M * N / P) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    logic          input_valid;
    logic          input_ready;
    logic          wr_en_x;
    logic [XW-1:0] wr_addr_x;
    logic          wr_bank_x;
    logic [XW-1:0] addr_x;
    logic          rd_bank_x;
    logic [AW-1:0] addr_w;
    logic          clear_acc;
    logic          en_acc;
    logic          capture;
    logic [PW-1:0] out_sel;
    logic          output_valid;
    logic          output_ready;
    logic          output_last;

    modport master (
        input  input_valid,
        output input_ready,
        output wr_en_x,
        output wr_addr_x,
        output wr_bank_x,
        output addr_x,
        output rd_bank_x,
        output addr_w,
        output clear_acc,
        output en_acc,
        output capture,
        output out_sel,
        output output_valid,
        input  output_ready,
        output output_last
    );

    modport slave (
        output input_valid,
        input  input_ready,
        input  wr_en_x,
        input  wr_addr_x,
        input  wr_bank_x,
        input  addr_x,
        input  rd_bank_x,
        input  addr_w,
        input  clear_acc,
        input  en_acc,
        input  capture,
        input  out_sel,
        input  output_valid,
        output output_ready,
        input  output_last
    );
endinterface

// File: rtl/mvm_sched_ctrl.sv
// -----------------------------------------------------------------------------
// mvm_sched_ctrl
// Sequencing controller for a P-lane matrix-vector MAC array (y = W*x).
// Loads an N-element x vector, then for each of M/P row groups issues N
// x/W reads, lets MAC_LAT cycles of pipeline drain, captures the lane
// accumulators and drains the P lane results one per output handshake.
// Carries no data, only control.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - synchronous, active-high; forces every output to 0
//   bus    - mvm_sched_ctrl_if.master (streams, memory and accumulator control)
//
// Optional feature:
//   MVM_SCHED_DOUBLE_BUFFER_EN - two ping-pong x banks so the next vector can
//   be loaded while the current one is computed. Undefined: single bank, input
//   accepted only in LOAD.
// -----------------------------------------------------------------------------
module mvm_sched_ctrl #(
    parameter int N       = 8,
    parameter int M       = 16,
    parameter int P       = 4,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    mvm_sched_ctrl_if.master bus
);
    localparam int G  = M / P;
    localparam int XW = $clog2(N);
    localparam int AW = (M * N / P > 1) ? $clog2(M * N / P) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int FW = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_COMPUTE,
        S_FLUSH,
        S_CAPTURE,
        S_DRAIN
    } state_e;

    state_e             state_q,  state_d;
    logic [XW-1:0]      wr_cnt_q, wr_cnt_d;   // x write index within vector
    logic [XW-1:0]      rd_cnt_q, rd_cnt_d;   // k, issue index within group
    logic [GW-1:0]      grp_q,    grp_d;      // g, current row group
    logic [PW-1:0]      sel_q,    sel_d;      // lane being drained
    logic [FW-1:0]      flush_q,  flush_d;    // FLUSH cycle counter
    logic [MAC_LAT-1:0] acc_sr_q, acc_sr_d;   // issue -> en_acc delay line

    logic in_ready, in_acc, acc_last;
    logic rd_bank_ready, next_bank_ready;
    logic last_sel, last_grp, drain_acc;
    logic issue, clear_c, capture_c, valid_c;
    logic wr_bank, rd_bank;

    assign in_acc    = bus.input_valid && in_ready;
    assign acc_last  = in_acc && (wr_cnt_q == XW'(N - 1));
    assign last_sel  = (sel_q == PW'(P - 1));
    assign last_grp  = (grp_q == GW'(G - 1));
    assign drain_acc = (state_q == S_DRAIN) && bus.output_ready;

`ifdef MVM_SCHED_DOUBLE_BUFFER_EN
    // Ping-pong banks: full_q marks banks holding a complete vector. The
    // write bank advances on its Nth accept, the read bank when the final
    // result of a vector leaves, so vectors are consumed in arrival order.
    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic       vec_done;

    assign vec_done        = drain_acc && last_sel && last_grp;
    assign in_ready        = !full_q[wr_bank_q];
    // A bank filling this very cycle counts, so COMPUTE follows the last
    // accept by exactly one cycle just as in the single-bank build.
    assign rd_bank_ready   = full_q[rd_bank_q]  || (acc_last && (wr_bank_q == rd_bank_q));
    assign next_bank_ready = full_q[!rd_bank_q] || (acc_last && (wr_bank_q != rd_bank_q));
    assign wr_bank         = wr_bank_q;
    assign rd_bank         = rd_bank_q;

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        // Release and fill never target the same bank: the bank being read is
        // full, so it cannot be the one accepting writes.
        if (vec_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
        if (acc_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end
`else
    assign in_ready        = (state_q == S_LOAD);
    assign rd_bank_ready   = acc_last;
    assign next_bank_ready = 1'b0;
    assign wr_bank         = 1'b0;
    assign rd_bank         = 1'b0;
`endif

    // Next-state and strobe logic.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        grp_d     = grp_q;
        sel_d     = sel_q;
        flush_d   = flush_q;
        issue     = 1'b0;
        clear_c   = 1'b0;
        capture_c = 1'b0;
        valid_c   = 1'b0;

        if (in_acc) begin
            wr_cnt_d = acc_last ? '0 : wr_cnt_q + XW'(1);
        end else begin
            wr_cnt_d = wr_cnt_q;
        end

        case (state_q)
            S_LOAD: begin
                if (rd_bank_ready) begin
                    state_d  = S_COMPUTE;
                    grp_d    = '0;
                    rd_cnt_d = '0;
                end
            end
            S_COMPUTE: begin
                issue   = 1'b1;
                clear_c = (rd_cnt_q == '0);
                if (rd_cnt_q == XW'(N - 1)) begin
                    rd_cnt_d = '0;
                    flush_d  = '0;
                    state_d  = S_FLUSH;
                end else begin
                    rd_cnt_d = rd_cnt_q + XW'(1);
                end
            end
            S_FLUSH: begin
                if (flush_q == FW'(MAC_LAT - 1)) begin
                    flush_d = '0;
                    state_d = S_CAPTURE;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            S_CAPTURE: begin
                capture_c = 1'b1;
                sel_d     = '0;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                valid_c = 1'b1;
                if (drain_acc) begin
                    if (last_sel) begin
                        sel_d = '0;
                        if (!last_grp) begin
                            grp_d   = grp_q + GW'(1);
                            state_d = S_COMPUTE;
                        end else begin
                            grp_d   = '0;
                            state_d = next_bank_ready ? S_COMPUTE : S_LOAD;
                        end
                    end else begin
                        sel_d = sel_q + PW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        // en_acc is the issue strobe delayed by exactly MAC_LAT cycles.
        acc_sr_d = (acc_sr_q << 1) | MAC_LAT'(issue);
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same edge, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            grp_q    <= '0;
            sel_q    <= '0;
            flush_q  <= '0;
            acc_sr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            grp_q    <= grp_d;
            sel_q    <= sel_d;
            flush_q  <= flush_d;
            acc_sr_q <= acc_sr_d;
        end
    end

    // Outputs are forced low combinationally while reset is high, so no
    // strobe escapes in the cycle reset is first sampled.
    always_comb begin
        bus.input_ready  = 1'b0;
        bus.wr_en_x      = 1'b0;
        bus.wr_addr_x    = '0;
        bus.wr_bank_x    = 1'b0;
        bus.addr_x       = '0;
        bus.rd_bank_x    = 1'b0;
        bus.addr_w       = '0;
        bus.clear_acc    = 1'b0;
        bus.en_acc       = 1'b0;
        bus.capture      = 1'b0;
        bus.out_sel      = '0;
        bus.output_valid = 1'b0;
        bus.output_last  = 1'b0;
        if (!reset) begin
            bus.input_ready  = in_ready;
            bus.wr_en_x      = in_acc;
            bus.wr_addr_x    = wr_cnt_q;
            bus.wr_bank_x    = wr_bank;
            bus.addr_x       = rd_cnt_q;
            bus.rd_bank_x    = rd_bank;
            if (state_q == S_COMPUTE) begin
                bus.addr_w = AW'(int'(grp_q) * N + int'(rd_cnt_q));
            end
            bus.clear_acc    = clear_c;
            bus.en_acc       = acc_sr_q[MAC_LAT-1];
            bus.capture      = capture_c;
            bus.out_sel      = sel_q;
            bus.output_valid = valid_c;
            bus.output_last  = valid_c && last_sel && last_grp;
        end
    end
endmodule

// File: tb/tb_mvm_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mvm_sched_ctrl
// Self-checking bench for mvm_sched_ctrl. A timeline model predicts every
// output each cycle: a group that starts at cycle t0 issues reads during
// t0..t0+N-1, accumulates MAC_LAT cycles later, captures at t0+N+MAC_LAT and
// drains from the cycle after. Bank occupancy is tracked as a count of full
// vectors. Honours MVM_SCHED_DOUBLE_BUFFER_EN when defined.
// -----------------------------------------------------------------------------
module tb_mvm_sched_ctrl;
    localparam int N       = 8;
    localparam int M       = 16;
    localparam int P       = 4;
    localparam int MAC_LAT = 2;
    localparam int G       = M / P;
`ifdef MVM_SCHED_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mvm_sched_ctrl_if #(.N(N), .M(M), .P(P)) bus ();

    mvm_sched_ctrl #(.N(N), .M(M), .P(P), .MAC_LAT(MAC_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    bit m_busy = 1'b0;
    int m_t0 = 0, m_g = 0, m_sel = 0, m_wcnt = 0, m_full = 0;
    int m_wvec = 0, m_rvec = 0, m_res = 0, m_acc_total = 0;

    // DUT-observed counters
    int obs_clear = 0, obs_en = 0, obs_cap = 0, obs_res = 0, obs_last = 0;
    int obs_stall = 0, obs_lacc = 0, obs_fv = 0;
    bit fv_arm = 1'b0;

    // Stimulus knobs
    int acc_target = 0;
    bit v_rand     = 1'b0;
    int rdy_mode   = 0;
    int stall_res  = -1;
    int stall_left = 0;

    int rel;
    bit e_ready, e_wr, e_comp, e_en, e_cap, e_valid, e_last;

    always @(negedge clk) begin
        if (reset) begin
            check("reset_outs",
                  int'({bus.input_ready, bus.wr_en_x, bus.wr_addr_x, bus.wr_bank_x,
                        bus.addr_x, bus.rd_bank_x, bus.addr_w, bus.clear_acc, bus.en_acc,
                        bus.capture, bus.out_sel, bus.output_valid, bus.output_last}), 0);
            m_busy = 1'b0; m_g = 0; m_sel = 0; m_wcnt = 0; m_full = 0;
            m_wvec = 0; m_rvec = 0; fv_arm = 1'b0;
        end else begin
            rel     = cyc - m_t0;
            e_ready = DB ? (m_full < 2) : (m_full == 0);
            e_wr    = bus.input_valid && e_ready;
            e_comp  = m_busy && rel >= 0 && rel < N;
            e_en    = m_busy && rel >= MAC_LAT && rel < N + MAC_LAT;
            e_cap   = m_busy && rel == N + MAC_LAT;
            e_valid = m_busy && rel > N + MAC_LAT;
            e_last  = e_valid && m_sel == P - 1 && m_g == G - 1;

            check("input_ready", bus.input_ready, e_ready);
            check("wr_en_x", bus.wr_en_x, e_wr);
            if (e_wr) check("wr_addr_x", bus.wr_addr_x, m_wcnt);
            check("wr_bank_x", bus.wr_bank_x, DB ? m_wvec % 2 : 0);
            check("rd_bank_x", bus.rd_bank_x, DB ? m_rvec % 2 : 0);
            check("clear_acc", bus.clear_acc, e_comp && rel == 0);
            check("en_acc", bus.en_acc, e_en);
            check("capture", bus.capture, e_cap);
            check("output_valid", bus.output_valid, e_valid);
            check("output_last", bus.output_last, e_last);
            if (e_comp) begin
                check("addr_x", bus.addr_x, rel);
                check("addr_w", bus.addr_w, m_g * N + rel);
            end
            if (e_valid) check("out_sel", bus.out_sel, m_sel);

            if (bus.clear_acc) obs_clear++;
            if (bus.en_acc) obs_en++;
            if (bus.capture) obs_cap++;
            if (bus.output_valid && !bus.output_ready) obs_stall++;
            if (bus.output_valid && bus.output_ready) begin
                obs_res++;
                if (bus.output_last) obs_last++;
            end
            if (bus.output_valid && fv_arm) begin obs_fv = cyc; fv_arm = 1'b0; end
            if (bus.wr_en_x && bus.wr_addr_x == N - 1) begin obs_lacc = cyc; fv_arm = 1'b1; end

            // Model update for the edge closing this cycle
            if (e_wr) begin
                m_acc_total++;
                if (m_wcnt == N - 1) begin m_wcnt = 0; m_full++; m_wvec++; end
                else m_wcnt++;
            end
            if (e_valid && bus.output_ready) begin
                m_res++;
                if (m_sel == P - 1) begin
                    m_sel = 0;
                    if (m_g == G - 1) begin m_full--; m_rvec++; m_busy = 1'b0; end
                    else begin m_g++; m_t0 = cyc + 1; end
                end else begin
                    m_sel++;
                end
            end
            if (!m_busy && m_full > 0) begin
                m_busy = 1'b1; m_t0 = cyc + 1; m_g = 0; m_sel = 0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.input_valid = (m_acc_total < acc_target) && (v_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        case (rdy_mode)
            0: bus.output_ready = 1'b1;
            1: bus.output_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (m_res == stall_res && stall_left > 0) begin
                    bus.output_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.output_ready = 1'b1;
                end
            end
        endcase
    endtask

    task automatic wait_vectors(input string tag, input int n, input int budget);
        int base = obs_last;
        int b = budget;
        while (obs_last < base + n && b > 0) begin step(); b--; end
        check(tag, obs_last - base, n);
    endtask

    int s_clear, s_en, s_cap, s_res, s_stall, b;

    initial begin
        bus.input_valid  = 1'b0;
        bus.output_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Back-to-back vector, no back-pressure
        s_clear = obs_clear; s_en = obs_en; s_cap = obs_cap; s_res = obs_res;
        acc_target += N; v_rand = 1'b0; rdy_mode = 0;
        wait_vectors("t1_done", 1, 400);
        check("t1_first_valid_lat", obs_fv - obs_lacc, N + MAC_LAT + 2);
        check("t1_clear_pulses", obs_clear - s_clear, G);
        check("t1_en_pulses", obs_en - s_en, G * N);
        check("t1_captures", obs_cap - s_cap, G);
        check("t1_results", obs_res - s_res, M);

        // Second result held off for 5 cycles
        s_stall = obs_stall; s_res = obs_res;
        stall_res = m_res + 1; stall_left = 5; rdy_mode = 2;
        acc_target += N;
        wait_vectors("t2_done", 1, 400);
        check("t2_stall_cycles", obs_stall - s_stall, 5);
        check("t2_results", obs_res - s_res, M);

        // Random valid and back-pressure over three vectors
        acc_target += 3 * N; v_rand = 1'b1; rdy_mode = 1;
        wait_vectors("t3_done", 3, 3000);

        // Reset in the third COMPUTE cycle, then a fresh vector
        acc_target = m_acc_total + N; v_rand = 1'b0; rdy_mode = 0;
        b = 400;
        while (!(m_busy && cyc - m_t0 == 2) && b > 0) begin step(); b--; end
        check("t4_compute3_addr_x", bus.addr_x, 2);
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        check("t4_ready_after_reset", bus.input_ready, 1);
        acc_target = m_acc_total + N;
        s_res = obs_res; s_clear = obs_clear;
        wait_vectors("t4_done", 1, 400);
        check("t4_results", obs_res - s_res, M);
        check("t4_clear_pulses", obs_clear - s_clear, G);

        // input_valid held high across three vectors
        acc_target += 3 * N; v_rand = 1'b0; rdy_mode = 0;
        wait_vectors("t5_done", 3, 1500);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
